mulalu_unit: RTL and testbench

Multiply/divide unit in the EX stage of the MIPS datapath. Owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU as multi-cycle operations, raising a stall to the pipeline until the result is committed. Also serves MFHI/MFLO reads and accepts MTHI/MTLO writes from the writeback stage.

---
 rtl/mulalu_if.sv | 30 +++
 rtl/mulalu_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mulalu_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mulalu_if.sv
// rtl/mulalu_if.sv - pipeline-side signal bundle of the multiply/divide unit
interface mulalu_if;
  logic        reg_stall;
  logic        alu_stall;
  logic        sign;
  logic [5:0]  func;
  logic [31:0] source_a;
  logic [31:0] source_b;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_write_data;
  logic [31:0] lo_write_data;

  // Pipeline side: presents the EX instruction and writeback MTHI/MTLO traffic.
  modport master (
    output reg_stall, sign, func, source_a, source_b,
    output hi_write, lo_write, hi_write_data, lo_write_data,
    input  alu_stall, result, hi, lo
  );

  // Unit side.
  modport slave (
    input  reg_stall, sign, func, source_a, source_b,
    input  hi_write, lo_write, hi_write_data, lo_write_data,
    output alu_stall, result, hi, lo
  );
endinterface

// File: rtl/mulalu_unit.sv
// rtl/mulalu_unit.sv - EX-stage multi-cycle MULT/DIV unit owning HI/LO (MULALU_ITER_MUL_EN selects shift-add multiply)
module mulalu_unit (
  input  logic     clk,
  input  logic     rst,
  mulalu_if.slave  bus
);

  localparam logic [5:0] FUNC_MFHI = 6'h10;
  localparam logic [5:0] FUNC_MFLO = 6'h12;
  localparam logic [5:0] FUNC_MULT = 6'h18;
  localparam logic [5:0] FUNC_DIV  = 6'h1A;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic        op_div;
  logic        neg_q;      // quotient (or product) must be negated at commit
  logic        neg_r;      // remainder must be negated at commit
  logic        div_zero;
  logic [31:0] a_q;        // raw dividend, returned in HI on divide by zero
  logic [31:0] opnd_b;     // divisor magnitude, or multiplicand magnitude in iterative mode
  logic [31:0] rem_q;      // partial remainder / product high half
  logic [31:0] quo_q;      // dividend-quotient shift register / product low half
  logic [4:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_mul;
  logic        is_div;
  logic        start;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign is_mul = (bus.func == FUNC_MULT);
  assign is_div = (bus.func == FUNC_DIV);
  assign start  = (state == IDLE) && (is_mul || is_div) && !rst;

  // The issue cycle stalls combinationally so the pipeline holds the operands.
  assign bus.alu_stall = start || (state == BUSY);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  assign a_neg = bus.sign & bus.source_a[31];
  assign b_neg = bus.sign & bus.source_b[31];
  assign a_mag = a_neg ? -bus.source_a : bus.source_a;
  assign b_mag = b_neg ? -bus.source_b : bus.source_b;

`ifndef MULALU_ITER_MUL_EN
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [65:0] mul_full;

  // Extending by the sign bit (or zero) lets one signed multiplier serve MULT and MULTU.
  assign mul_a    = $signed({a_neg, bus.source_a});
  assign mul_b    = $signed({b_neg, bus.source_b});
  assign mul_full = mul_a * mul_b;
`else
  logic [32:0] mul_sum;

  // Shift-add: add the multiplicand when the current multiplier bit is set.
  assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_b} : 33'd0);
`endif

  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_sub;

  // The trial difference is below the divisor, so its low 32 bits are exact.
  assign div_sh  = {rem_q, quo_q[31]};
  assign div_ge  = (div_sh >= {1'b0, opnd_b});
  assign div_sub = div_sh[31:0] - opnd_b;

  logic [31:0] step_rem;
  logic [31:0] step_quo;

  // One iteration of the shared shift datapath.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    if (op_div) begin
      step_rem = div_ge ? div_sub : div_sh[31:0];
      step_quo = {quo_q[30:0], div_ge};
    end else begin
`ifdef MULALU_ITER_MUL_EN
      step_rem = mul_sum[32:1];
      step_quo = {mul_sum[0], quo_q[31:1]};
`endif
    end
  end

  logic [31:0] commit_hi;
  logic [31:0] commit_lo;
`ifdef MULALU_ITER_MUL_EN
  logic [63:0] prod_mag;
  logic [63:0] prod_fix;

  assign prod_mag = {step_rem, step_quo};
  assign prod_fix = neg_q ? -prod_mag : prod_mag;
`endif

  // Final HI/LO values: sign correction and divide-by-zero override.
  always_comb begin
    commit_hi = rem_q;
    commit_lo = quo_q;
    if (op_div) begin
      if (div_zero) begin
        commit_hi = a_q;
        commit_lo = 32'hFFFF_FFFF;
      end else begin
        commit_hi = neg_r ? -step_rem : step_rem;
        commit_lo = neg_q ? -step_quo : step_quo;
      end
    end else begin
`ifdef MULALU_ITER_MUL_EN
      commit_hi = prod_fix[63:32];
      commit_lo = prod_fix[31:0];
`endif
    end
  end

  // Control FSM, operand latching, iteration and HI/LO ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_q      <= '0;
      opnd_b   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      // Writeback moves come first so a same-edge commit overrides them.
      if (bus.hi_write) hi_q <= bus.hi_write_data;
      if (bus.lo_write) lo_q <= bus.lo_write_data;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= BUSY;
            op_div   <= is_div;
            a_q      <= bus.source_a;
            div_zero <= is_div && (bus.source_b == 32'd0);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            if (is_div) begin
              opnd_b <= b_mag;
              rem_q  <= '0;
              quo_q  <= a_mag;
              cnt    <= 5'd31;
            end else begin
`ifdef MULALU_ITER_MUL_EN
              opnd_b <= a_mag;
              rem_q  <= '0;
              quo_q  <= b_mag;
              cnt    <= 5'd31;
`else
              opnd_b <= b_mag;
              rem_q  <= mul_full[63:32];
              quo_q  <= mul_full[31:0];
              cnt    <= 5'd0;
`endif
            end
          end
        end
        BUSY: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            hi_q  <= commit_hi;
            lo_q  <= commit_lo;
            state <= DONE;
          end
        end
        DONE: begin
          // The finished instruction is still presented while the pipeline is stalled.
          if (!bus.reg_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MFHI/MFLO read port with writeback bypass.
  always_comb begin
    bus.result = '0;
    if (!rst) begin
      if (bus.func == FUNC_MFHI) begin
        bus.result = bus.hi_write ? bus.hi_write_data : hi_q;
      end else if (bus.func == FUNC_MFLO) begin
        bus.result = bus.lo_write ? bus.lo_write_data : lo_q;
      end
    end
  end

endmodule

// File: tb/tb_mulalu_unit.sv
// tb/tb_mulalu_unit.sv - scoreboard bench for mulalu_unit
module tb_mulalu_unit;

  localparam logic [5:0] F_NOP  = 6'h00;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam int DIV_LEN = 33;
`ifdef MULALU_ITER_MUL_EN
  localparam int MUL_LEN = 33;
`else
  localparam int MUL_LEN = 2;
`endif

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic tie_stall;
  logic ext_stall;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mon_run = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mulalu_if bus ();

  mulalu_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.reg_stall = tie_stall ? bus.alu_stall : ext_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each completed stall burst is one retired operation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.alu_stall === 1'b1) begin
        mon_run++;
        if (mon_run > 200) begin
          n_tests++;
          n_fail++;
          $display("FAIL stall_timeout: stall still high after %0d cycles", mon_run);
          mon_run = 0;
        end
      end else if (mon_run > 0) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_op: stall burst of %0d cycles with nothing expected", mon_run);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_stall_len"}, mon_run, mon_e.len);
          check({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
          check({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
        end
        mon_run = 0;
      end
    end
  end

  task automatic do_op(input string name, input logic sgn, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input int len, input int hold, input logic hw);
    exp_t e;
    bit   done;
    e.name = name;
    e.hi   = exp_hi;
    e.lo   = exp_lo;
    e.len  = len;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.sign          = sgn;
    bus.func          = f;
    bus.source_a      = a;
    bus.source_b      = b;
    bus.hi_write      = hw;
    bus.hi_write_data = 32'h1234_5678;
    @(posedge clk); #1;
    bus.source_a = ~a;
    bus.source_b = ~b;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.alu_stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_done_timeout: alu_stall never dropped", name);
    end
    bus.hi_write = 1'b0;
    if (hold > 0) begin
      tie_stall = 1'b0;
      ext_stall = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, "_held_no_restart"}, {31'd0, bus.alu_stall}, 32'd0);
      end
      ext_stall = 1'b0;
      tie_stall = 1'b1;
    end
    bus.func = F_NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    tie_stall         = 1'b1;
    ext_stall         = 1'b0;
    bus.sign          = 1'b0;
    bus.func          = F_NOP;
    bus.source_a      = '0;
    bus.source_b      = '0;
    bus.hi_write      = 1'b0;
    bus.lo_write      = 1'b0;
    bus.hi_write_data = '0;
    bus.lo_write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.func = F_MFHI;
    @(negedge clk);
    check("reset_alu_stall", {31'd0, bus.alu_stall}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_result", bus.result, 32'd0);
    bus.func = F_NOP;

    do_op("div_19_m4",     1'b1, F_DIV,  32'd19,        32'hFFFF_FFFC, 32'd3,         32'hFFFF_FFFC, DIV_LEN, 0, 1'b0);
    do_op("divu_max_2",    1'b0, F_DIV,  32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF, DIV_LEN, 0, 1'b0);
    do_op("divu_by_zero",  1'b0, F_DIV,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, DIV_LEN, 0, 1'b0);
    do_op("div_by_zero_s", 1'b1, F_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LEN, 0, 1'b0);
    do_op("div_overflow",  1'b1, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LEN, 0, 1'b0);
    do_op("div_m19_4",     1'b1, F_DIV,  32'hFFFF_FFED, 32'd4,         32'hFFFF_FFFD, 32'hFFFF_FFFC, DIV_LEN, 0, 1'b0);
    do_op("mult_m3_5",     1'b1, F_MULT, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LEN, 0, 1'b0);
    do_op("multu_m3_5",    1'b0, F_MULT, 32'hFFFF_FFFD, 32'd5,         32'd4,         32'hFFFF_FFF1, MUL_LEN, 0, 1'b0);
    do_op("multu_max",     1'b0, F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         MUL_LEN, 0, 1'b0);
    do_op("mult_min_min",  1'b1, F_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         MUL_LEN, 0, 1'b0);
    do_op("commit_wins",   1'b1, F_MULT, 32'd6,         32'd7,         32'd0,         32'd42,        MUL_LEN, 0, 1'b1);
    do_op("divu_held",     1'b0, F_DIV,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LEN, 5, 1'b0);

    // Reset in the 11th stall cycle of a DIV: aborted, HI/LO cleared.
    begin
      exp_t e;
      e.name = "rst_abort";
      e.hi   = 32'd0;
      e.lo   = 32'd0;
      e.len  = 11;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.sign     = 1'b1;
    bus.func     = F_DIV;
    bus.source_a = 32'd19;
    bus.source_b = 32'hFFFF_FFFC;
    repeat (10) @(posedge clk);
    #1;
    rst      = 1'b1;
    bus.func = F_NOP;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort_stall", {31'd0, bus.alu_stall}, 32'd0);
    check("rst_abort_hi", bus.hi, 32'd0);

    do_op("div_after_rst", 1'b1, F_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, DIV_LEN, 0, 1'b0);

    // MFHI/MFLO with writeback bypass.
    @(posedge clk); #1;
    bus.func          = F_MFHI;
    bus.hi_write      = 1'b1;
    bus.hi_write_data = 32'hA5A5_A5A5;
    @(negedge clk);
    check("mfhi_bypass", bus.result, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    bus.hi_write      = 1'b0;
    bus.func          = F_MFLO;
    bus.lo_write      = 1'b1;
    bus.lo_write_data = 32'h5A5A_0FF0;
    @(negedge clk);
    check("mthi_hi", bus.hi, 32'hA5A5_A5A5);
    check("mflo_bypass", bus.result, 32'h5A5A_0FF0);
    @(posedge clk); #1;
    bus.lo_write = 1'b0;
    bus.func     = F_MFHI;
    @(negedge clk);
    check("mtlo_lo", bus.lo, 32'h5A5A_0FF0);
    check("mfhi_reg", bus.result, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    bus.func = F_NOP;
    @(negedge clk);
    check("nop_result", bus.result, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
